// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential multiplier between NREQ requesters,
// with a watchdog on the multiplier done and a valid/ready response port.
module mult_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [TW-1:0]    timer;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   scan_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             timed_out;

  assign timed_out = (timer == TW'(TIMEOUT - 1));

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_id = IDW'((32'(ptr) + k) % NREQ);
      if (!grant_any && req_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accept strobe is only meaningful on an edge that actually latches the winner.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = clr_n;
          state_nxt           = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_done || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ptr         <= IDW'(NREQ - 1);
      timer       <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mul_start <= (state == IDLE) && grant_any;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            rsp_id <= grant_id;
          end
        end
        ISSUE: timer <= '0;
        // A done arriving in the last allowed cycle still beats the watchdog.
        WAIT: begin
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
          end else if (timed_out) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
